// File: rtl/gf256_inverse_seq_pkg.sv
// Shared definitions for the sequential GF(2^8) inverter: FSM encoding and
// field constants for the AES polynomial x^8+x^4+x^3+x+1.
package gf256_inverse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Low byte of the field polynomial; the x^8 term is implied by the reduction.
  localparam logic [7:0] RED_POLY = 8'h1B;
  localparam logic [2:0] ROUNDS   = 3'd7;
  localparam logic [7:0] ACC_INIT = 8'h01;

endpackage : gf256_inverse_seq_pkg

// File: rtl/gf256_inverse_seq_gf_mul.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product followed by
// reduction of the upper seven bits with the field polynomial.
module gf256_inverse_seq_gf_mul
  import gf256_inverse_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [14:0] partial [8];
  logic [14:0] product;
  logic [14:0] reduced;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_partial
      assign partial[gi] = b[gi] ? ({7'b0, a} << gi) : 15'h0000;
    end
  endgenerate

  always_comb begin
    product = 15'h0000;
    for (int i = 0; i < 8; i++) begin
      product = product ^ partial[i];
    end
  end

  // Fold bits 14..8 down from the top so each fold can set lower high bits
  // that are folded in a later iteration.
  always_comb begin
    reduced = product;
    for (int k = 14; k >= 8; k--) begin
      if (reduced[k]) begin
        reduced[k]          = 1'b0;
        reduced[k-8 +: 8]   = reduced[k-8 +: 8] ^ RED_POLY;
      end
    end
  end

  assign p = reduced[7:0];

endmodule : gf256_inverse_seq_gf_mul

// File: rtl/gf256_inverse_seq.sv
// Sequential GF(2^8) inverter computing a^254 by square-and-multiply over
// seven rounds, sharing one multiplier between the square and multiply steps.
module gf256_inverse_seq
  import gf256_inverse_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  state_t     state_reg, state_next;
  logic [7:0] sq_reg, sq_next;
  logic [7:0] acc_reg, acc_next;
  logic [2:0] round_reg, round_next;

  logic [7:0] mul_a;
  logic [7:0] mul_p;

  // SQUARE uses (sq, sq); MULT uses (acc, sq).
  assign mul_a = (state_reg == MULT) ? acc_reg : sq_reg;

  gf256_inverse_seq_gf_mul u_gf_mul (
    .a (mul_a),
    .b (sq_reg),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sq_reg    <= 8'h00;
      acc_reg   <= 8'h00;
      round_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      sq_reg    <= sq_next;
      acc_reg   <= acc_next;
      round_reg <= round_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sq_next    = sq_reg;
    acc_next   = acc_reg;
    round_next = round_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;

    case (state_reg)
      IDLE: begin
        // Gated by rst_n so the port reads 0 while reset is held.
        in_ready = rst_n;
        if (in_valid) begin
          state_next = SQUARE;
          sq_next    = in_data;
          acc_next   = ACC_INIT;
          round_next = 3'd1;
        end
      end
      SQUARE: begin
        sq_next    = mul_p;
        state_next = MULT;
      end
      MULT: begin
        acc_next = mul_p;
        if (round_reg == ROUNDS) begin
          state_next = DONE;
        end else begin
          round_next = round_reg + 3'd1;
          state_next = SQUARE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : gf256_inverse_seq

// File: doc/gf256_inverse_seq.md
GF256_INVERSE_SEQ -- requirements
Module: gf256_inverse_seq

Interface
REQ-001 The block SHALL have no parameters; the reduction constant 8'h1B SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream holds a byte to invert.
REQ-005 in_ready  output  1  block can accept a byte.
REQ-006 in_data  input  8  GF(2^8) operand a.
REQ-007 out_valid  output  1  out_data holds a^-1.
REQ-008 out_ready  input  1  downstream (affine transform) accepts the result.
REQ-009 out_data  output  8  multiplicative inverse of a, with 0 mapping to 0.

Function
REQ-010 The block SHALL compute out_data = a^254 mod x^8+x^4+x^3+x+1, which gives a^-1 for a!=0 and 0 for a=0, with no special case for zero.
REQ-011 The FSM SHALL have exactly four states: IDLE, SQUARE, MULT, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 An input is accepted on a rising edge where in_valid&&in_ready; on acceptance sq<=in_data, acc<=8'h01, round<=1, state<=SQUARE.
REQ-014 In IDLE without in_valid the block SHALL stay in IDLE and hold sq, acc and round unchanged.
REQ-015 In SQUARE, each edge SHALL do sq<=sq*sq and state<=MULT.
REQ-016 In MULT, each edge SHALL do acc<=acc*sq; if round==7 then state<=DONE, else round<=round+1 and state<=SQUARE.
REQ-017 round SHALL be 3 bits, range 1..7, and SHALL never wrap.
REQ-018 Compute latency SHALL be fixed at 14 edges: out_valid rises on the 14th rising edge after the accepting edge, independent of data.
REQ-019 out_data SHALL equal acc in DONE and SHALL stay stable while out_valid&&!out_ready.
REQ-020 On an edge in DONE with out_ready=1, state<=IDLE; in_ready rises the next cycle.
REQ-021 There SHALL be no input accept in the same cycle as the output handshake. Minimum initiation interval is 16 cycles.
REQ-022 in_data SHALL be sampled only on the accepting edge; changes to in_data at any other time SHALL have no effect.
REQ-023 in_valid asserted outside IDLE SHALL be ignored and not queued; upstream holds it until in_ready.
REQ-024 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-025 While rst_n=0, regardless of clk: state=IDLE, sq=8'h00, acc=8'h00, round=0.
REQ-026 Outputs during reset SHALL be in_ready=0, out_valid=0, out_data=8'h00.
REQ-027 After rst_n deasserts, in_ready SHALL read 1 (IDLE); the first accept may occur on the first rising edge after deassertion.
REQ-028 Reset asserted mid-computation or in DONE SHALL abort the operation immediately; the pending result is discarded and never presented.

Structure
REQ-029 The shared package SHALL hold the state enum {IDLE, SQUARE, MULT, DONE}, RED_POLY=8'h1B, ROUNDS=7 and ACC_INIT=8'h01.
REQ-030 The block SHALL contain exactly one instance of the existing combinational GF(2^8) multiplier.
REQ-031 That multiplier SHALL be time-shared: operands (sq,sq) in SQUARE and (acc,sq) in MULT, selected by a 2:1 mux on the state.
REQ-032 The only registers SHALL be state, sq, acc and round; there SHALL be no output pipeline register.

Verification
REQ-033 Accept in_data=8'h53 with out_ready=1 -> out_valid rises exactly 14 edges later with out_data=8'hCA; through the downstream affine transform this gives 8'hED.
REQ-034 Inputs 8'h00, 8'h01, 8'h02 -> out_data 8'h00, 8'h01, 8'h8D respectively.
REQ-035 All 256 inputs against a reference model -> every result satisfies a*out==1 (out=0 for a=0), with latency 14 for every input.
REQ-036 in_data=8'h53 with out_ready held 0 for 10 cycles -> out_valid stays 1 and out_data stays 8'hCA; in_ready stays 0; in_valid pulses in that window are ignored.
REQ-037 rst_n pulsed low during MULT round 4 -> outputs 0 immediately; after release, in_ready=1, and a new input 8'h02 yields 8'h8D with no stale result.
REQ-038 Back-to-back stream with in_valid and out_ready always 1 -> one result every 16 cycles, in order, and no drops.
